wait_state_ctrl: RTL and testbench

WAIT_STATE_CTRL -- requirements
Module: wait_state_ctrl

---
 rtl/wait_state_ctrl.sv | 128 ++++++++++++
 tb/tb_wait_state_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wait_state_ctrl.sv
// Decodes the CPU address into regions and holds rdy low for a per-region wait count.
// A slow-device ready can extend the wait in flagged regions.
module wait_state_ctrl #(
  parameter int ADDR_W = 16,
  parameter int NREG = 4,
  parameter int WAIT_W = 4,
  parameter int CNT_W = 32,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = '0,
  parameter logic [NREG*WAIT_W-1:0] REG_WAIT = '0,
  parameter logic [NREG-1:0] REG_EXT = '0,
  parameter int DEFAULT_WAIT = 1,
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int REG_W = $clog2(NREG + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ab,
  input  logic              we,
  input  logic              ext_ready,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic              rdy,
  output logic [REG_W-1:0]  region,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              err
);

  typedef enum logic [1:0] {S_START, S_WAIT, S_EXT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] r_table [NREG];
  logic [REG_W-1:0]  r_region;
  logic [ADDR_W-1:0] r_ab;
  logic              r_we;
  logic              r_ext;
  logic [CNT_W-1:0]  r_stall;
  logic              r_err;

  logic [REG_W-1:0]  w_dec_reg;
  logic [WAIT_W-1:0] w_dec_wait;
  logic              w_dec_ext;
  logic              w_rdy;
  logic              w_viol;

  // Scan from the top so the lowest matching region is the last one assigned.
  always_comb begin
    w_dec_reg  = REG_W'(NREG);
    w_dec_wait = WAIT_W'(DEFAULT_WAIT);
    w_dec_ext  = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((ab & REG_MASK[i*ADDR_W +: ADDR_W]) == REG_BASE[i*ADDR_W +: ADDR_W]) begin
        w_dec_reg  = REG_W'(i);
        w_dec_wait = r_table[i];
        w_dec_ext  = REG_EXT[i];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b0;
    case (r_state)
      S_START: begin
        if (w_dec_wait == '0) begin
          w_rdy  = !w_dec_ext || ext_ready;
          w_next = w_rdy ? S_START : S_EXT;
        end else begin
          w_next = (w_dec_wait == WAIT_W'(1)) ? S_EXT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == WAIT_W'(1)) w_next = S_EXT;
      end
      S_EXT: begin
        w_rdy = !r_ext || ext_ready;
        if (w_rdy) w_next = S_START;
      end
      default: w_next = S_START;
    endcase
  end

  // Only mid-access stall cycles are checked; the start cycle defines the reference.
  assign w_viol = (r_state != S_START) && !w_rdy && ((ab != r_ab) || (we != r_we));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_START;
      r_cnt    <= '0;
      r_region <= REG_W'(NREG);
      r_ab     <= '0;
      r_we     <= 1'b0;
      r_ext    <= 1'b0;
      r_stall  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_START) begin
        r_cnt    <= (w_dec_wait == '0) ? '0 : w_dec_wait - WAIT_W'(1);
        r_region <= w_dec_reg;
        r_ab     <= ab;
        r_we     <= we;
        r_ext    <= w_dec_ext;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - WAIT_W'(1);
      end
      if (!w_rdy && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
      r_err <= r_err | w_viol;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_table[i] <= REG_WAIT[i*WAIT_W +: WAIT_W];
    end else if (cfg_we && (32'(cfg_idx) < NREG)) begin
      r_table[cfg_idx] <= cfg_wait;
    end
  end

  assign rdy       = w_rdy && !reset;
  assign region    = r_region;
  assign stall_cnt = r_stall;
  assign err       = r_err;

endmodule

// File: tb/tb_wait_state_ctrl.sv
// Directed bench for wait_state_ctrl: region decode, wait patterns, ext gating,
// runtime table writes, protocol error and reset behaviour.
module tb_wait_state_ctrl;

  localparam int ADDR_W = 16;
  localparam int NREG   = 5;
  localparam int WAIT_W = 4;
  localparam int CNT_W  = 4;
  localparam logic [NREG*ADDR_W-1:0] BASE = {16'h5000, 16'h4000, 16'h8000, 16'hE000, 16'h0000};
  localparam logic [NREG*ADDR_W-1:0] MASK = {16'hF000, 16'hF000, 16'hF000, 16'hE000, 16'hC000};
  localparam logic [NREG*WAIT_W-1:0] WTAB = {4'd0, 4'd3, 4'd1, 4'd2, 4'd0};
  localparam logic [NREG-1:0]        EXT  = 5'b10100;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] ab;
  logic              we;
  logic              ext_ready;
  logic              cfg_we;
  logic [2:0]        cfg_idx;
  logic [WAIT_W-1:0] cfg_wait;
  logic              rdy;
  logic [2:0]        region;
  logic [CNT_W-1:0]  stall_cnt;
  logic              err;

  int n_vec = 0;
  int n_err = 0;

  wait_state_ctrl #(
    .ADDR_W(ADDR_W), .NREG(NREG), .WAIT_W(WAIT_W), .CNT_W(CNT_W),
    .REG_BASE(BASE), .REG_MASK(MASK), .REG_WAIT(WTAB), .REG_EXT(EXT),
    .DEFAULT_WAIT(1)
  ) dut (
    .clk(clk), .reset(reset), .ab(ab), .we(we), .ext_ready(ext_ready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wait(cfg_wait),
    .rdy(rdy), .region(region), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One access: rdy low for n cycles, high in cycle n; any pending cfg write lasts one cycle.
  task automatic access(input string tag, input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      chk(tag, {31'd0, rdy}, (i == n) ? 32'd1 : 32'd0);
      adv();
      cfg_we = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; ab = 16'h0400; we = 1'b0; ext_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_wait = '0;
    @(negedge clk);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    adv();
    chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_region", {29'd0, region}, 32'd5);

    // Zero-wait region 0
    reset = 1'b0;
    access("r0_a", 0);
    access("r0_b", 0);
    access("r0_c", 0);
    chk("r0_region", {29'd0, region}, 32'd0);
    chk("r0_stall", {28'd0, stall_cnt}, 32'd0);

    // Region 1, two waits
    ab = 16'hF000;
    access("r1_a", 2);
    chk("r1_stall1", {28'd0, stall_cnt}, 32'd2);
    chk("r1_region", {29'd0, region}, 32'd1);
    access("r1_b", 2);
    chk("r1_stall2", {28'd0, stall_cnt}, 32'd4);

    // Region 2, one wait then ext_ready low for three more cycles
    ab = 16'h8010; ext_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ext_ready = 1'b1;
      @(negedge clk);
      chk("ext_r2", {31'd0, rdy}, (i == 4) ? 32'd1 : 32'd0);
      adv();
    end
    chk("ext_region", {29'd0, region}, 32'd2);
    chk("ext_stall", {28'd0, stall_cnt}, 32'd8);

    // No match: default wait 1, ext_ready ignored
    ab = 16'h6000; ext_ready = 1'b0;
    access("nomatch", 1);
    chk("nomatch_region", {29'd0, region}, 32'd5);

    // Region 4: zero wait but ext-gated
    ab = 16'h5000;
    @(negedge clk); chk("z_ext0", {31'd0, rdy}, 32'd0); adv();
    @(negedge clk); chk("z_ext1", {31'd0, rdy}, 32'd0); adv();
    ext_ready = 1'b1;
    @(negedge clk); chk("z_ext2", {31'd0, rdy}, 32'd1); adv();
    access("z_ext3", 0);
    chk("z_region", {29'd0, region}, 32'd4);
    chk("z_stall", {28'd0, stall_cnt}, 32'd11);

    // Table write during an access leaves it unchanged
    ab = 16'hF000;
    @(negedge clk); chk("cfg_a0", {31'd0, rdy}, 32'd0); adv();
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_wait = 4'd5;
    @(negedge clk); chk("cfg_a1", {31'd0, rdy}, 32'd0); adv();
    cfg_we = 1'b0;
    @(negedge clk); chk("cfg_a2", {31'd0, rdy}, 32'd1); adv();
    access("cfg_n5", 5);
    // Write coinciding with an access start uses the old value
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_wait = 4'd3;
    access("cfg_same", 5);
    access("cfg_n3", 3);
    // Out-of-range index ignored
    cfg_we = 1'b1; cfg_idx = 3'd7; cfg_wait = 4'd0;
    access("oor_a", 3);
    access("oor_b", 3);
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);

    // Address change mid-access sets sticky err
    @(negedge clk); chk("err_a0", {31'd0, rdy}, 32'd0); adv();
    ab = 16'hF001;
    @(negedge clk); chk("err_pre", {31'd0, err}, 32'd0); adv();
    chk("err_set", {31'd0, err}, 32'd1);
    ab = 16'hF000;
    @(negedge clk); chk("err_a2", {31'd0, rdy}, 32'd0); adv();
    @(negedge clk); chk("err_a3", {31'd0, rdy}, 32'd1); adv();
    chk("err_hold", {31'd0, err}, 32'd1);

    // Reset mid-wait aborts, reloads table and clears status
    @(negedge clk); chk("rw_a0", {31'd0, rdy}, 32'd0); adv();
    reset = 1'b1;
    @(negedge clk); chk("rw_rdy", {31'd0, rdy}, 32'd0); adv();
    chk("rw_err", {31'd0, err}, 32'd0);
    chk("rw_stall", {28'd0, stall_cnt}, 32'd0);
    chk("rw_region", {29'd0, region}, 32'd5);
    @(negedge clk); chk("rw_rdy2", {31'd0, rdy}, 32'd0); adv();
    chk("rw_stall2", {28'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    access("post_rst", 2);
    chk("post_stall", {28'd0, stall_cnt}, 32'd2);
    chk("post_region", {29'd0, region}, 32'd1);

    // we change mid-access also flags err
    @(negedge clk); chk("we_a0", {31'd0, rdy}, 32'd0); adv();
    we = 1'b1;
    @(negedge clk); chk("we_a1", {31'd0, rdy}, 32'd0); adv();
    chk("we_err", {31'd0, err}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
